// File: rtl/fetch_unit_pkg.sv
// Shared MIPS definitions for the fetch slice.
//   NOP_WORD_C : add $0,$0,$0, used for bubbles and out-of-range fetches
//   opcode_e   : primary opcode field encodings
//   funct_e    : R-type funct field encodings
//   pc_plus4() : sequential PC increment, modulo 2^32
package fetch_unit_pkg;

    localparam logic [31:0] NOP_WORD_C = 32'h0000_0020;

    typedef enum logic [5:0] {
        OP_R    = 6'b000000,
        OP_J    = 6'b000010,
        OP_BEQ  = 6'b000100,
        OP_BNE  = 6'b000101,
        OP_ADDI = 6'b001000,
        OP_ANDI = 6'b001100,
        OP_LW   = 6'b100011,
        OP_SW   = 6'b101011
    } opcode_e;

    typedef enum logic [5:0] {
        FN_ADD = 6'b100000,
        FN_SUB = 6'b100010,
        FN_SLT = 6'b101010
    } funct_e;

    function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/fetch_unit_imem_rom.sv
// Word-addressed instruction memory with range-checked combinational read.
// The array has no write port; benches preload it hierarchically as
// <inst>.instruction[i].
//   i_word_addr : byte PC with the two low bits already dropped
//   o_word      : instruction[i_word_addr], or NOP_WORD when out of range
module imem_rom
    import fetch_unit_pkg::*;
#(
    parameter int          IMEM_DEPTH = 256,
    parameter logic [31:0] NOP_WORD   = NOP_WORD_C
) (
    input  logic [29:0] i_word_addr,
    output logic [31:0] o_word
);

    localparam int AW = (IMEM_DEPTH > 1) ? $clog2(IMEM_DEPTH) : 1;

    logic [31:0] instruction [0:IMEM_DEPTH-1];
    logic        w_in_range;

    // Compare the full word address so any high bit set maps to NOP_WORD.
    assign w_in_range = ({2'b00, i_word_addr} < 32'(IMEM_DEPTH));

    always_comb begin
        o_word = NOP_WORD;
        if (w_in_range) begin
            o_word = instruction[i_word_addr[AW-1:0]];
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage of the 5-stage MIPS pipeline.
// Holds the PC, reads the instruction ROM and loads the IF/ID register.
// Edge priority: redirect > stall > sequential fetch.
//   clk          : rising-edge clock
//   rst          : asynchronous active-low reset
//   stall        : hold PC and IF/ID
//   redirect     : taken branch/jump from ID, squashes the wrong-path word
//   redirect_pc  : redirect target, sampled only when redirect=1
//   fd_ir        : IF/ID instruction word
//   fd_pc        : IF/ID PC+4 of fd_ir (0 for a bubble)
//   fd_valid     : 1 = real fetch, 0 = bubble
//   pc           : current fetch address
//   fetch_count  : real fetches loaded into IF/ID, saturating
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int          IMEM_DEPTH = 256,
    parameter logic [31:0] NOP_WORD   = NOP_WORD_C,
    parameter int          CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             redirect,
    input  logic [31:0]      redirect_pc,
    output logic [31:0]      fd_ir,
    output logic [31:0]      fd_pc,
    output logic             fd_valid,
    output logic [31:0]      pc,
    output logic [CNT_W-1:0] fetch_count
);

    logic [31:0]      r_pc;
    logic [31:0]      r_fd_ir;
    logic [31:0]      r_fd_pc;
    logic             r_fd_valid;
    logic [CNT_W-1:0] r_fetch_count;
    logic [31:0]      w_word;
    logic [31:0]      w_pc_next;

    imem_rom #(
        .IMEM_DEPTH (IMEM_DEPTH),
        .NOP_WORD   (NOP_WORD)
    ) IF_ROM (
        .i_word_addr (r_pc[31:2]),
        .o_word      (w_word)
    );

    assign w_pc_next = pc_plus4(r_pc);

    // redirect_pc is only looked at inside the redirect branch, so an
    // undriven target with redirect=0 never reaches r_pc.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pc          <= '0;
            r_fd_ir       <= NOP_WORD;
            r_fd_pc       <= '0;
            r_fd_valid    <= 1'b0;
            r_fetch_count <= '0;
        end else if (redirect) begin
            r_pc       <= redirect_pc;
            r_fd_ir    <= NOP_WORD;
            r_fd_pc    <= '0;
            r_fd_valid <= 1'b0;
        end else if (!stall) begin
            r_pc       <= w_pc_next;
            r_fd_ir    <= w_word;
            r_fd_pc    <= w_pc_next;
            r_fd_valid <= 1'b1;
            if (r_fetch_count != '1) begin
                r_fetch_count <= r_fetch_count + CNT_W'(1);
            end
        end
    end

    assign pc          = r_pc;
    assign fd_ir       = r_fd_ir;
    assign fd_pc       = r_fd_pc;
    assign fd_valid    = r_fd_valid;
    assign fetch_count = r_fetch_count;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed reset/stall/redirect/boundary
// steps followed by a randomized phase, all checked against a cycle-level
// reference model built from the fetch rules. A narrow counter is used so
// saturation is reached within the run.
module tb_fetch_unit;

    localparam int          DEPTH = 256;
    localparam int          CW    = 4;
    localparam logic [31:0] NOP   = 32'h0000_0020;

    logic          clk;
    logic          rst;
    logic          stall;
    logic          redirect;
    logic [31:0]   redirect_pc;
    logic [31:0]   fd_ir;
    logic [31:0]   fd_pc;
    logic          fd_valid;
    logic [31:0]   pc;
    logic [CW-1:0] fetch_count;

    fetch_unit #(
        .IMEM_DEPTH (DEPTH),
        .NOP_WORD   (NOP),
        .CNT_W      (CW)
    ) fetch (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .fd_ir       (fd_ir),
        .fd_pc       (fd_pc),
        .fd_valid    (fd_valid),
        .pc          (pc),
        .fetch_count (fetch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned checks = 0;
    int unsigned errors = 0;

    logic [31:0] mem [0:DEPTH-1];

    // Reference model state
    logic [31:0] m_pc, m_ir, m_fpc;
    logic        m_valid;
    int unsigned m_cnt;

    function automatic logic [31:0] model_word(input logic [31:0] a);
        int unsigned idx;
        idx = int'(a >> 2);
        if ((a >> 2) < 32'(DEPTH)) return mem[idx];
        return NOP;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".fd_ir"},       fd_ir,            m_ir);
        check({tag, ".fd_pc"},       fd_pc,            m_fpc);
        check({tag, ".fd_valid"},    32'(fd_valid),    32'(m_valid));
        check({tag, ".pc"},          pc,               m_pc);
        check({tag, ".fetch_count"}, 32'(fetch_count), m_cnt);
    endtask

    task automatic model_reset();
        m_pc = '0; m_ir = NOP; m_fpc = '0; m_valid = 1'b0; m_cnt = 0;
    endtask

    // Drive one cycle's inputs, advance the model, check after the edge.
    task automatic step(input string tag, input logic s, input logic r, input logic [31:0] rp);
        stall = s; redirect = r; redirect_pc = rp;
        if (r) begin
            m_pc = rp; m_ir = NOP; m_fpc = '0; m_valid = 1'b0;
        end else if (!s) begin
            m_ir    = model_word(m_pc);
            m_fpc   = m_pc + 32'd4;
            m_valid = 1'b1;
            m_pc    = m_pc + 32'd4;
            if (m_cnt < (2**CW) - 1) m_cnt++;
        end
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    initial begin
        rst = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
        for (int i = 0; i < DEPTH; i++) begin
            mem[i] = $urandom;
            fetch.IF_ROM.instruction[i] = mem[i];
        end
        mem[0] = 32'h2008_0001; fetch.IF_ROM.instruction[0] = mem[0];
        mem[1] = 32'h2009_0002; fetch.IF_ROM.instruction[1] = mem[1];
        mem[2] = 32'h0109_5020; fetch.IF_ROM.instruction[2] = mem[2];
        mem[3] = 32'h8c0b_0010; fetch.IF_ROM.instruction[3] = mem[3];
        mem[4] = 32'hac0b_0014; fetch.IF_ROM.instruction[4] = mem[4];
        model_reset();

        // Reset held across the first edge; released at 12ns.
        #11;
        check_all("reset");
        #1 rst = 1'b1;

        // Sequential fetch, then a 3-cycle stall while fd_pc=8.
        step("seq1", 1'b0, 1'b0, 'x);
        step("seq2", 1'b0, 1'b0, 'x);
        for (int i = 0; i < 3; i++) step("stall", 1'b1, 1'b0, 'x);
        step("after_stall", 1'b0, 1'b0, 'x);
        for (int i = 0; i < 3; i++) step("seq", 1'b0, 1'b0, 'x);

        // Redirect to word 127 from pc=0x18: bubble, then target word.
        check("pc_before_redirect", pc, 32'h18);
        step("redir_bubble", 1'b0, 1'b1, 32'h1FC);
        step("redir_target", 1'b0, 1'b0, 'x);

        // Redirect wins over a simultaneous stall.
        step("redir_stall", 1'b1, 1'b1, 32'h64);

        // Last legal word, then an out-of-range fetch.
        step("redir_last", 1'b0, 1'b1, 32'(4*DEPTH-4));
        step("last_word", 1'b0, 1'b0, 'x);
        step("oor_fetch", 1'b0, 1'b0, 'x);

        // PC wrap from 0xFFFFFFFC to 0.
        step("redir_top", 1'b0, 1'b1, 32'hFFFF_FFFC);
        step("wrap", 1'b0, 1'b0, 'x);
        step("after_wrap", 1'b0, 1'b0, 'x);

        // Randomized traffic, long enough to saturate the counter.
        for (int i = 0; i < 400; i++) begin
            logic        s, r;
            logic [31:0] rp;
            s  = ($urandom_range(0, 3) == 0);
            r  = ($urandom_range(0, 9) == 0);
            rp = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC
                 : (32'($urandom_range(0, DEPTH + 3)) << 2) | 32'($urandom_range(0, 3));
            step("rand", s, r, r ? rp : 'x);
        end

        // Asynchronous reset mid-cycle.
        #3 rst = 1'b0;
        #1;
        model_reset();
        check_all("async_reset");
        #2 rst = 1'b1;
        step("post_reset1", 1'b0, 1'b0, 'x);
        step("post_reset2", 1'b0, 1'b0, 'x);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
